mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_pkg.sv | 27 ++
 rtl/mem_req_arbiter_id_fifo.sv | 62 ++++++
 rtl/mem_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter shared types: requester IDs, grant FSM states, sizes.
// No ports; imported by mem_req_arbiter and arb_id_fifo.
package mem_req_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] ARB_SIZE_BYTE = 2'd0;
  localparam logic [1:0] ARB_SIZE_HALF = 2'd1;
  localparam logic [1:0] ARB_SIZE_WORD = 2'd2;

  // Data wins when it requests and either inst is idle or data has priority.
  function automatic logic arb_pick_data(
    input logic inst_req,
    input logic data_req,
    input logic prefer_data
  );
    return data_req & (~inst_req | prefer_data);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// arb_id_fifo: in-order 1-bit requester-ID FIFO for outstanding transactions.
// Ports: clk, resetn (sync, active-low), push_i/id_i, pop_i, full_o, empty_o, head_o.
module arb_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= id_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow wraps naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like port between inst fetch and data.
// Ports: inst_* / data_* upstream requesters, req..wdata/addr_ok/data_ok/rdata
// downstream. Optional macro ARB_RR_EN selects round-robin instead of data-first.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  arb_state_e state_q;
  logic       en_q;
  logic       en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       prefer_data;
  logic       pick_data;
  logic       gnt_vld;
  logic       gnt_id;
  logic       push;
  logic       pop;

  // Outputs stay quiet during reset and the first cycle after release.
  always_ff @(posedge clk) begin
    if (!resetn) en_q <= 1'b0;
    else         en_q <= 1'b1;
  end

  assign en = resetn & en_q;

`ifdef ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (!resetn)   last_q <= ARB_ID_DATA;
    else if (push) last_q <= gnt_id;
  end

  assign prefer_data = (last_q == ARB_ID_INST);
`else
  assign prefer_data = 1'b1;
`endif

  assign pick_data = arb_pick_data(inst_req, data_req, prefer_data);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ARB_ID_INST;
    unique case (state_q)
      ARB_IDLE: begin
        if (!fifo_full && (inst_req || data_req)) begin
          gnt_vld = 1'b1;
          gnt_id  = pick_data ? ARB_ID_DATA : ARB_ID_INST;
        end
      end
      ARB_LOCK_I: begin
        gnt_vld = inst_req;
        gnt_id  = ARB_ID_INST;
      end
      ARB_LOCK_D: begin
        gnt_vld = data_req;
        gnt_id  = ARB_ID_DATA;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = ARB_ID_INST;
      end
    endcase
  end

  assign req  = en & gnt_vld;
  assign push = req & addr_ok;
  assign pop  = en & data_ok & ~fifo_empty;

  assign inst_addr_ok = push & (gnt_id == ARB_ID_INST);
  assign data_addr_ok = push & (gnt_id == ARB_ID_DATA);

  always_comb begin
    wr    = 1'b0;
    wstrb = 4'h0;
    size  = inst_size;
    addr  = inst_addr;
    wdata = inst_wdata;
    if (req) begin
      if (gnt_id == ARB_ID_DATA) begin
        wr    = data_wr;
        wstrb = data_wstrb;
        size  = data_size;
        addr  = data_addr;
        wdata = data_wdata;
      end else begin
        wr    = inst_wr;
        wstrb = inst_wstrb;
      end
    end
  end

  // A handshake that stalls in IDLE pins the grant until addr_ok.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (req && !addr_ok) begin
            state_q <= (gnt_id == ARB_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
          end
        end
        ARB_LOCK_I, ARB_LOCK_D: begin
          if (push) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign inst_data_ok = pop & (fifo_head == ARB_ID_INST);
  assign data_data_ok = pop & (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  arb_id_fifo #(
    .DEPTH(OUTST_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (push),
    .id_i   (gnt_id),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: table-driven grant checks plus a response scoreboard.
// Build with ARB_RR_EN defined to exercise the round-robin sequence.
module tb_mem_req_arbiter;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_0100;
  localparam logic [31:0] IW = 32'haaaa_0000;
  localparam logic [31:0] DW = 32'h5555_1234;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;
  logic sb[$];

  typedef struct {
    logic        ir;
    logic        dr;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_req;
    logic        e_gnt;
  } vec_t;

  vec_t tbl[17];

  mem_req_arbiter #(.OUTST_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok,
                       input logic dok, input logic [31:0] rd);
    inst_req = ir;
    data_req = dr;
    addr_ok  = aok;
    data_ok  = dok;
    rdata    = rd;
  endtask

  task automatic chk_resp(input logic dok_in, input logic [31:0] rd);
    logic eid;
    logic ei;
    logic ed;
    ei = 1'b0;
    ed = 1'b0;
    if (dok_in && sb.size() > 0) begin
      eid = sb.pop_front();
      ei  = ~eid;
      ed  = eid;
    end
    chk("inst_data_ok", inst_data_ok, ei);
    chk("data_data_ok", data_data_ok, ed);
    if (dok_in) begin
      chk("inst_rdata", inst_rdata, rd);
      chk("data_rdata", data_rdata, rd);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    step();
    step();
    resetn = 1'b1;
    step();
    sb.delete();
  endtask

  initial begin
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'h3;
    inst_addr  = IA;
    inst_wdata = IW;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_wstrb = 4'hf;
    data_addr  = DA;
    data_wdata = DW;

    //            ir dr aok dok rd          req gnt
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};

    // Reset with both requesting and downstream handshakes high.
    resetn = 1'b0;
    drive(1, 1, 1, 1, 32'hdead);
    step();
    step();
    chk("rst_req", req, 1'b0);
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_data_data_ok", data_data_ok, 1'b0);
    resetn = 1'b1;
    drive(1, 1, 1, 0, 32'h0);
    #1;
    chk("rel_req", req, 1'b0);
    chk("rel_data_addr_ok", data_addr_ok, 1'b0);
    step();

`ifndef ARB_RR_EN
    for (int i = 0; i < 17; i++) begin
      logic gd;
      drive(tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok, tbl[i].rd);
      #1;
      gd = tbl[i].e_req & tbl[i].e_gnt;
      chk($sformatf("v%0d_req", i), req, tbl[i].e_req);
      chk($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok,
          tbl[i].e_req & tbl[i].aok & ~tbl[i].e_gnt);
      chk($sformatf("v%0d_data_addr_ok", i), data_addr_ok,
          tbl[i].e_req & tbl[i].aok & tbl[i].e_gnt);
      chk($sformatf("v%0d_addr", i), addr, gd ? DA : IA);
      chk($sformatf("v%0d_wdata", i), wdata, gd ? DW : IW);
      chk($sformatf("v%0d_size", i), size, gd ? 2'd1 : 2'd2);
      chk($sformatf("v%0d_wr", i), wr, gd);
      chk($sformatf("v%0d_wstrb", i), wstrb,
          !tbl[i].e_req ? 4'h0 : (tbl[i].e_gnt ? 4'hf : 4'h3));
      chk_resp(tbl[i].dok, tbl[i].rd);
      if (tbl[i].e_req && tbl[i].aok) sb.push_back(tbl[i].e_gnt);
      step();
    end
    chk("tbl_sb_drained", sb.size(), 0);
`endif

    // Reset while two transactions are outstanding.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, 32'h0);
      #1;
      chk("pre_inst_addr_ok", inst_addr_ok, 1'b1);
      sb.push_back(1'b0);
      step();
    end
    resetn = 1'b0;
    drive(1, 0, 1, 1, 32'h99);
    #1;
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("mid_rst_inst_data_ok", inst_data_ok, 1'b0);
    step();
    step();
    resetn = 1'b1;
    sb.delete();
    drive(0, 0, 0, 1, 32'h99);
    #1;
    chk_resp(1'b1, 32'h99);
    step();
    chk_resp(1'b1, 32'h99);
    drive(1, 0, 1, 0, 32'h0);
    #1;
    chk("post_rst_inst_addr_ok", inst_addr_ok, 1'b1);
    sb.push_back(1'b0);
    step();
    drive(0, 0, 0, 1, 32'hbeef);
    #1;
    chk_resp(1'b1, 32'hbeef);
    step();
    drive(0, 0, 0, 1, 32'hbeef);
    #1;
    chk_resp(1'b1, 32'hbeef);
    step();

`ifdef ARB_RR_EN
    begin
      logic last;
      do_reset();
      last = 1'b1;
      for (int i = 0; i < 4; i++) begin
        drive(1, 1, 1, 0, 32'h0);
        #1;
        chk($sformatf("rr%0d_data_addr_ok", i), data_addr_ok, ~last);
        chk($sformatf("rr%0d_inst_addr_ok", i), inst_addr_ok, last);
        chk($sformatf("rr%0d_addr", i), addr, last ? IA : DA);
        last = ~last;
        sb.push_back(last);
        step();
      end
      for (int i = 0; i < 4; i++) begin
        drive(0, 0, 0, 1, 32'h100 + i);
        #1;
        chk_resp(1'b1, 32'h100 + i);
        step();
      end
    end
`endif

    drive(0, 0, 0, 0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
